// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART bus sequencer: FSM states,
// register addresses and the baud-divisor lookup.
package spart_pkg;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD_RX,
        WR_TX,
        GAP
    } state_t;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Divisor for a 50 MHz clock: round(3.125e6 / baud) - 1
    function automatic logic [15:0] div_for(input logic [1:0] br_cfg);
        logic [15:0] div;
        unique case (br_cfg)
            2'b00:   div = 16'h028A;
            2'b01:   div = 16'h0145;
            2'b10:   div = 16'h00A2;
            default: div = 16'h0050;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/spart_byte_fifo.sv
// Synchronous DEPTH x 8 byte FIFO holding received bytes awaiting echo.
module spart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spart_seq_ctrl.sv
// SPART bus master: programs the baud divisor after reset or on br_cfg change,
// then echoes every received byte back to the transmitter through a byte FIFO.
module spart_seq_ctrl
    import spart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       br_cfg,
    input  logic             rda,
    input  logic             tbr,
    output logic             iocs,
    output logic             iorw,
    output logic [1:0]       ioaddr,
    inout  wire  [7:0]       databus,
    output logic             cfg_done,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic             busy
);

    state_t      state;
    state_t      state_nxt;
    logic        iocs_d;
    logic        iorw_d;
    logic [1:0]  ioaddr_d;
    logic [7:0]  dout_q;
    logic [7:0]  dout_d;
    logic        cfg_done_d;
    logic [1:0]  br_cfg_q;
    logic [1:0]  br_cfg_d;
    logic        last_rx;
    logic        last_rx_d;
    logic [15:0] div_val;
    logic [7:0]  fifo_head;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        rd_ok;
    logic        wr_ok;

    // Bus outputs are registered: the access chosen in a state appears on the
    // bus the following cycle and completes (push/pop) at the edge after that.
    assign push    = iocs && iorw && (ioaddr == ADDR_BUF);
    assign pop     = iocs && !iorw && (ioaddr == ADDR_BUF);
    assign databus = (iocs && !iorw) ? dout_q : 8'hzz;
    assign busy    = (state != IDLE);
    assign div_val = div_for((state == CFG_LO) ? br_cfg : br_cfg_q);

    spart_byte_fifo #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (databus),
        .dout (fifo_head),
        .full (full),
        .empty(empty),
        .count(fifo_cnt)
    );

    always_comb begin
        state_nxt  = state;
        iocs_d     = 1'b0;
        iorw_d     = 1'b1;
        ioaddr_d   = ADDR_STAT;
        dout_d     = dout_q;
        cfg_done_d = cfg_done;
        br_cfg_d   = br_cfg_q;
        last_rx_d  = last_rx;
        rd_ok      = rda && !full;
        wr_ok      = tbr && !empty;

        if (iocs && !iorw && (ioaddr == ADDR_DBH)) cfg_done_d = 1'b1;

        unique case (state)
            CFG_LO: begin
                // br_cfg is sampled here rather than at reset so reset stays constant
                iocs_d    = 1'b1;
                iorw_d    = 1'b0;
                ioaddr_d  = ADDR_DBL;
                dout_d    = div_val[7:0];
                br_cfg_d  = br_cfg;
                state_nxt = CFG_HI;
            end
            CFG_HI: begin
                iocs_d    = 1'b1;
                iorw_d    = 1'b0;
                ioaddr_d  = ADDR_DBH;
                dout_d    = div_val[15:8];
                state_nxt = IDLE;
            end
            IDLE: begin
                if (br_cfg != br_cfg_q) begin
                    cfg_done_d = 1'b0;
                    state_nxt  = CFG_LO;
                end else if (rd_ok && wr_ok) begin
                    state_nxt = last_rx ? WR_TX : RD_RX;
                end else if (rd_ok) begin
                    state_nxt = RD_RX;
                end else if (wr_ok) begin
                    state_nxt = WR_TX;
                end
            end
            RD_RX: begin
                iocs_d    = 1'b1;
                iorw_d    = 1'b1;
                ioaddr_d  = ADDR_BUF;
                last_rx_d = 1'b1;
                state_nxt = GAP;
            end
            WR_TX: begin
                iocs_d    = 1'b1;
                iorw_d    = 1'b0;
                ioaddr_d  = ADDR_BUF;
                dout_d    = fifo_head;
                last_rx_d = 1'b0;
                state_nxt = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = CFG_LO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CFG_LO;
            iocs     <= 1'b0;
            iorw     <= 1'b1;
            ioaddr   <= ADDR_STAT;
            dout_q   <= '0;
            cfg_done <= 1'b0;
            br_cfg_q <= '0;
            last_rx  <= 1'b0;
        end else begin
            state    <= state_nxt;
            iocs     <= iocs_d;
            iorw     <= iorw_d;
            ioaddr   <= ioaddr_d;
            dout_q   <= dout_d;
            cfg_done <= cfg_done_d;
            br_cfg_q <= br_cfg_d;
            last_rx  <= last_rx_d;
        end
    end

endmodule

// File: tb/tb_spart_seq_ctrl.sv
// Scoreboard bench for spart_seq_ctrl with a behavioural SPART model on the bus.
module tb_spart_seq_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int ALT_N = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       br_cfg = 2'b01;
    logic             rda = 1'b0;
    logic             tbr = 1'b0;
    logic             iocs;
    logic             iorw;
    logic [1:0]       ioaddr;
    wire  [7:0]       databus;
    logic             cfg_done;
    logic [CNT_W-1:0] fifo_cnt;
    logic             busy;
    logic [7:0]       rx_data = 8'h00;

    int          checks = 0;
    int          fails = 0;
    byte unsigned rx_q[$];
    byte unsigned exp_q[$];
    logic [9:0]  cfg_q[$];
    int          model_cnt = 0;
    bit          pend_pop = 1'b0;
    int          cyc = 0;
    int          last_acc = -100;
    int          last_type = -1;
    int          alt_left = 0;

    always #5 clk = ~clk;

    assign databus = (iocs && iorw) ? rx_data : 8'hzz;

    spart_seq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .br_cfg  (br_cfg),
        .rda     (rda),
        .tbr     (tbr),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .cfg_done(cfg_done),
        .fifo_cnt(fifo_cnt),
        .busy    (busy)
    );

    function automatic logic [15:0] ref_div(input logic [1:0] sel);
        int baud;
        baud = 4800 << sel;
        return 16'((3125000 + baud / 2) / baud - 1);
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input byte unsigned b);
        rx_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic expect_cfg(input logic [1:0] sel);
        logic [15:0] d;
        d = ref_div(sel);
        cfg_q.push_back({2'b10, d[7:0]});
        cfg_q.push_back({2'b11, d[15:8]});
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        tbr = 1'b1;
        while ((exp_q.size() != 0 || rx_q.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(exp_q.size() == 0 && rx_q.size() == 0, "drain", exp_q.size(), 0);
    endtask

    task automatic wait_cnt(input int v, input int maxc);
        int n;
        n = 0;
        while (int'(fifo_cnt) != v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(int'(fifo_cnt) == v, "fifo_fill", int'(fifo_cnt), v);
    endtask

    // SPART model and scoreboard: every bus access is checked against the queues
    always @(negedge clk) begin
        int cur_type;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < model_cnt; i++) void'(exp_q.pop_front());
            model_cnt = 0;
            pend_pop  = 1'b0;
            last_type = -1;
            last_acc  = -100;
        end else begin
            if (pend_pop) begin
                void'(rx_q.pop_front());
                pend_pop = 1'b0;
            end
            chk(int'(fifo_cnt) == model_cnt, "fifo_cnt", int'(fifo_cnt), model_cnt);
            if (iocs) begin
                if (!iorw && ioaddr[1]) begin
                    if (cfg_q.size() == 0) begin
                        chk(1'b0, "cfg_write_unexpected", int'({ioaddr, databus}), 0);
                    end else begin
                        chk({ioaddr, databus} == cfg_q[0], "cfg_write",
                            int'({ioaddr, databus}), int'(cfg_q[0]));
                        void'(cfg_q.pop_front());
                    end
                    chk(cfg_done == 1'b0, "cfg_done_low", int'(cfg_done), 0);
                end else if (ioaddr == 2'b00) begin
                    cur_type = iorw ? 0 : 1;
                    chk(cyc - last_acc >= 3, "access_spacing", cyc - last_acc, 3);
                    if (alt_left > 0) begin
                        chk(cur_type != last_type, "alternate", cur_type, 1 - last_type);
                        if (alt_left < ALT_N)
                            chk(cyc - last_acc == 3, "alt_period", cyc - last_acc, 3);
                        alt_left--;
                    end
                    if (iorw) begin
                        chk(rx_q.size() > 0 && model_cnt < DEPTH, "read_allowed", model_cnt, DEPTH - 1);
                        if (rx_q.size() > 0 && model_cnt < DEPTH) begin
                            model_cnt++;
                            pend_pop = 1'b1;
                        end
                    end else if (exp_q.size() == 0 || model_cnt == 0) begin
                        chk(1'b0, "write_allowed", model_cnt, 1);
                    end else begin
                        chk(databus == exp_q[0], "echo_data", int'(databus), int'(exp_q[0]));
                        void'(exp_q.pop_front());
                        model_cnt--;
                    end
                    last_type = cur_type;
                    last_acc  = cyc;
                end else begin
                    chk(1'b0, "bus_access", int'({iorw, ioaddr}), 0);
                end
            end
        end
        rda     = (rx_q.size() != 0);
        rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    initial begin
        logic [15:0] d;
        bit          found;
        int          since;

        // reset values and divisor programming for 9600
        repeat (3) @(negedge clk);
        chk(iocs == 1'b0, "rst_iocs", int'(iocs), 0);
        chk(iorw == 1'b1, "rst_iorw", int'(iorw), 1);
        chk(ioaddr == 2'b01, "rst_ioaddr", int'(ioaddr), 1);
        chk(cfg_done == 1'b0, "rst_cfg_done", int'(cfg_done), 0);
        chk(fifo_cnt == '0, "rst_fifo_cnt", int'(fifo_cnt), 0);
        chk(busy == 1'b1, "rst_busy", int'(busy), 1);
        d = ref_div(2'b01);
        expect_cfg(2'b01);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk(iocs && !iorw && ioaddr == 2'b10, "cfg_lo_access", int'({iocs, iorw, ioaddr}), 'b1010);
        chk(databus == d[7:0], "cfg_lo_data", int'(databus), int'(d[7:0]));
        @(posedge clk); #1;
        chk(iocs && !iorw && ioaddr == 2'b11, "cfg_hi_access", int'({iocs, iorw, ioaddr}), 'b1011);
        chk(databus == d[15:8], "cfg_hi_data", int'(databus), int'(d[15:8]));
        @(posedge clk); #1;
        chk(cfg_done == 1'b1, "cfg_done_set", int'(cfg_done), 1);
        chk(iocs == 1'b0, "idle_iocs", int'(iocs), 0);

        // single byte echo
        @(negedge clk);
        tbr = 1'b1;
        send(8'hA5);
        drain(100);

        // fill to DEPTH with TX blocked; fifth byte must stay in the SPART
        @(negedge clk);
        tbr = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i * 8'h11));
        repeat (40) @(negedge clk);
        chk(int'(fifo_cnt) == DEPTH, "fifo_full", int'(fifo_cnt), DEPTH);
        chk(rda == 1'b1, "rda_held", int'(rda), 1);
        chk(rx_q.size() == 1 && rx_q[0] == 8'h55, "byte_left_unread", rx_q.size(), 1);
        drain(200);

        // both sides eligible: strict alternation at one access per 3 cycles
        @(negedge clk);
        tbr = 1'b0;
        send(8'h3C);
        send(8'hC3);
        wait_cnt(2, 50);
        repeat (3) @(negedge clk);
        tbr = 1'b1;
        alt_left = ALT_N;
        for (int i = 0; i < 6; i++) send(8'($urandom));
        for (int n = 0; n < 80 && alt_left > 0; n++) @(negedge clk);
        chk(alt_left == 0, "alt_count", alt_left, 0);
        alt_left = 0;
        drain(200);

        // br_cfg change during a TX write
        @(negedge clk);
        tbr = 1'b0;
        for (int i = 0; i < 3; i++) send(8'($urandom));
        wait_cnt(3, 60);
        @(negedge clk);
        tbr = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            @(posedge clk); #1;
            found = iocs && !iorw && (ioaddr == 2'b00);
        end
        chk(found, "wr_tx_seen", int'(found), 1);
        br_cfg = 2'b11;
        tbr = 1'b0;
        expect_cfg(2'b11);
        repeat (12) @(negedge clk);
        chk(int'(fifo_cnt) == 2, "fifo_kept", int'(fifo_cnt), 2);
        chk(cfg_done == 1'b1, "reprog_done", int'(cfg_done), 1);
        chk(cfg_q.size() == 0, "reprog_writes", cfg_q.size(), 0);
        drain(200);

        // reset during an RX read with three bytes held
        @(negedge clk);
        tbr = 1'b0;
        for (int i = 0; i < 5; i++) send(8'($urandom));
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            @(posedge clk); #1;
            found = iocs && iorw && (ioaddr == 2'b00) && (int'(fifo_cnt) == 3);
        end
        chk(found, "rd_rx_at_3", int'(found), 1);
        rst_n = 1'b0;
        #1;
        chk(iocs == 1'b0, "async_iocs", int'(iocs), 0);
        chk(fifo_cnt == '0, "async_fifo_cnt", int'(fifo_cnt), 0);
        repeat (2) @(negedge clk);
        expect_cfg(br_cfg);
        d = ref_div(br_cfg);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk(iocs && !iorw && ioaddr == 2'b10 && databus == d[7:0], "cfg_after_rst",
            int'({ioaddr, databus}), int'({2'b10, d[7:0]}));
        drain(200);

        // randomized traffic with occasional baud changes
        since = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0 && rx_q.size() < 6) send(8'($urandom));
            if ($urandom_range(7) == 0) tbr = ~tbr;
            since++;
            if (since > 30 && $urandom_range(40) == 0) begin
                br_cfg = br_cfg + 2'($urandom_range(3, 1));
                expect_cfg(br_cfg);
                since = 0;
            end
        end
        drain(400);
        repeat (10) @(negedge clk);
        chk(cfg_q.size() == 0, "final_cfg_writes", cfg_q.size(), 0);
        chk(cfg_done == 1'b1, "final_cfg_done", int'(cfg_done), 1);
        chk(fifo_cnt == '0, "final_fifo_cnt", int'(fifo_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spart_seq_ctrl.md
Name: spart_seq_ctrl

Overview:
Bus-side sequencer for the SPART register interface (iocs/iorw/ioaddr/databus, rda/tbr status). After reset it loads the baud divisor selected by br_cfg, then runs a continuous echo loop. Every received byte is read into an internal byte FIFO and written back to the transmitter when tbr allows. It is the sole bus master of the SPART at the top level and reprograms the divisor whenever br_cfg changes.

Parameters:
DEPTH, 4, echo FIFO entries (power of 2, >=2)
CNT_W, 3, width of fifo_cnt, equal to $clog2(DEPTH)+1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400 (synchronous to clk)
rda  in  1  SPART receive data available
tbr  in  1  SPART transmit buffer ready
iocs  out  1  bus chip select, one-cycle strobe per access
iorw  out  1  1=read, 0=write
ioaddr  out  2  00=TX/RX buffer, 01=status, 10=DB low, 11=DB high
databus  inout  8  driven only when iocs=1 and iorw=0, else 'z
cfg_done  out  1  divisor programmed for current br_cfg
fifo_cnt  out  CNT_W  bytes held in echo FIFO
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=CFG_LO, iocs=0, iorw=1, ioaddr=01, databus='z, cfg_done=0, FIFO empty, fifo_cnt=0, br_cfg_q=br_cfg, last_rx=0.
- Divisor table at 50 MHz, value=round(3.125e6/baud)-1: 4800=0x028A, 9600=0x0145, 19200=0x00A2, 38400=0x0050.
- Bus access: a single cycle with iocs=1. A write drives databus from the rising edge. A read samples databus at the next rising edge while iocs=1 and iorw=1.
- States: CFG_LO, CFG_HI, IDLE, RD_RX, WR_TX, GAP.
- CFG_LO: write div[7:0] to ioaddr 10, then go to CFG_HI.
- CFG_HI: write div[15:8] to ioaddr 11, set cfg_done=1, then go to IDLE. First echo access is therefore no earlier than the 3rd cycle after reset release.
- IDLE: iocs=0. Priority order, evaluated every cycle:
  1. br_cfg != br_cfg_q: capture br_cfg_q, clear cfg_done, go to CFG_LO. FIFO contents are preserved.
  2. If rda and FIFO not full, and tbr and FIFO not empty, both are eligible: serve the side opposite to last_rx.
  3. Else if only rda and FIFO not full: go to RD_RX.
  4. Else if only tbr and FIFO not empty: go to WR_TX.
- RD_RX: iocs=1, iorw=1, ioaddr=00; push databus into the FIFO at the edge; last_rx=1; go to GAP.
- WR_TX: iocs=1, iorw=0, ioaddr=00, databus=FIFO head; pop at the edge; last_rx=0; go to GAP.
- GAP: one idle cycle so SPART rda/tbr can update, then go to IDLE. Throughput is at most one access per 3 cycles.
- FIFO full while rda=1: no read is issued; the byte stays held in the SPART. No data is ever dropped by this block.
- FIFO empty while tbr=1: no write is issued.
- A br_cfg change during CFG_LO/CFG_HI/RD_RX/WR_TX/GAP is acted on only at the next IDLE; the sequence in progress is not aborted.
- fifo_cnt changes only on push or pop, by ±1. Push and pop never occur in the same cycle.
- Reset mid-operation: all state returns to the reset values immediately and FIFO contents are lost. iocs drops asynchronously.

Decomposition:
- spart_pkg: state_t enum; address constants ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11; function div_for(br_cfg) returning 16 bits.
- Sub-module spart_byte_fifo: synchronous FIFO, DEPTH x 8, with push/pop/full/empty/count. Pointers wrap modulo DEPTH; count is CNT_W bits.
- Remaining logic (FSM, bus drive, tri-state) lives in spart_seq_ctrl.

Test Plan:
1. Reset with br_cfg=01, release -> cycle 1: iocs=1, iorw=0, ioaddr=10, databus=0x45; cycle 2: ioaddr=11, databus=0x01; cycle 3 onward: cfg_done=1, iocs=0.
2. Model asserts rda with byte 0xA5, tbr=1 -> RD_RX read at ioaddr 00 captures 0xA5, GAP, then WR_TX drives 0xA5 at ioaddr 00; fifo_cnt goes 0→1→0.
3. tbr=0, rda presenting 0x11,0x22,0x33,0x44,0x55 -> exactly 4 reads, fifo_cnt=4, rda left high and 0x55 not read. Raise tbr -> writes 0x11..0x44 in order, then 0x55 is read and echoed.
4. rda and tbr both held high with FIFO at 2 -> reads and writes strictly alternate (R,W,R,W), each followed by one GAP cycle.
5. br_cfg changes 01→11 while in WR_TX -> write completes, GAP, then CFG_LO/CFG_HI write 0x50/0x00; cfg_done is low for those 2 cycles and FIFO contents are unchanged.
6. rst_n asserted during RD_RX with fifo_cnt=3 -> iocs=0 and databus='z immediately, fifo_cnt=0; after release the CFG_LO sequence repeats.
